tensor_serializer2d: RTL and testbench
======================================

# tensor_serializer2d

Streams a flat, channel-major feature-map vector (the concatenated output of the channel-concat stage) out as a sequence of WIDTH-bit elements over a valid/ready handshake. Each beat carries its element coordinates. It sits directly downstream of the concat stage and converts its parallel bus into a narrow stream for line buffers, writeback, or off-chip transfer.

## Interface
- CH, default 2: channels in the input tensor. This is A_CH+B_CH of the feeding concat.
- IN_H, default 1: tensor height.
- IN_W, default 1: tensor width.
- WIDTH, default 16: element width in bits.
- LANES, default 1: elements per output beat. Must divide IN_W; elaboration fails otherwise.
- precision, default "Q8.8": numeric format tag, carried for consistency only. The data path is bit-transparent.
- clk  in  1  single clock. All logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_vec  in  CH*IN_H*IN_W*WIDTH  flat tensor. Element e = c*IN_H*IN_W + h*IN_W + w sits at bits [e*WIDTH +: WIDTH].
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a tensor.
- out_data  out  LANES*WIDTH  lane k holds element (beat*LANES + k) at [k*WIDTH +: WIDTH].
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_last  out  1  final beat of the tensor.
- out_ch, out_row, out_col  out  CH_W, H_W, W_W  coordinates of lane 0. Each width is max(1, clog2(dim)).

## Operation
- FSM has two states, IDLE and STREAM. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_vec into a shadow buffer, clear all counters, and go to STREAM.
- STREAM:
  - out_valid=1. out_data, out_last and the coordinates are driven from registered state.
  - Each out_valid&&out_ready handshake advances one beat:
    - col += LANES.
    - When col wraps past IN_W: col=0, row+1.
    - When row wraps past IN_H: row=0, ch+1.
  - out_last=1 when ch=CH-1, row=IN_H-1 and col=IN_W-LANES.
- Back-to-back transfer:
  - in_ready is also 1 in STREAM during the cycle in which the last beat handshakes (out_valid&&out_ready&&out_last). in_ready is combinational from state and out_ready.
  - If in_valid is also 1 in that cycle, capture the new tensor, reset the counters and stay in STREAM.
  - Otherwise go to IDLE.
- In STREAM outside the last-beat handshake, in_ready=0. in_valid is ignored and the shadow buffer is not modified.
- out_valid never drops once raised until the handshake completes. With out_ready low, all outputs hold stable.
- Element values pass through unchanged. There is no sign extension, rounding or reordering.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, out_ch/out_row/out_col=0, state IDLE, in_ready=1 (in_ready follows from IDLE).
- Asynchronous assert clears everything immediately, including mid-stream. A partially sent tensor is dropped with no resume.
- Latency: tensor accepted at edge t gives beat 0 valid after edge t. Throughput is 1 beat per cycle with out_ready held high.
- Back-to-back tensors: beat 0 of tensor N+1 follows the last beat of tensor N on the next cycle, with zero bubble.
- Beats per tensor = CH*IN_H*IN_W/LANES.
- Degenerate case CH=IN_H=IN_W=LANES=1: every beat is both first and last.

## Structure
- The shared package tensor_pkg holds:
  - the idx_width(dim) function (max(1,$clog2(dim))),
  - the serializer state enum typedef (S_IDLE, S_STREAM),
  - the element-index helper constants.
- One natural sub-module, tensor_index_counter: a three-level wrapping counter (col step LANES, row, ch) with en, clr, and a last flag. It can be reused by a future deserializer.

## Test plan
- CH=2, IN_H=2, IN_W=2, WIDTH=16, LANES=1; element e = 16'h0100+e; out_ready=1.
  - Expect 8 consecutive beats 0x0100..0x0107.
  - (ch,row,col) runs from (0,0,0) to (1,1,1).
  - out_last only on beat 7. in_ready=0 on beats 0–6.
- Same config, out_ready toggled 1,0,0,1 repeating.
  - out_data and the coordinates hold while out_ready=0.
  - No beat is skipped or duplicated. Count is exactly 8.
- Two tensors offered back-to-back with in_valid held high, second tensor e = 16'h0200+e.
  - Beat 0x0200 appears the cycle after beat 0x0107.
  - in_ready=1 in the cycle of that last handshake only.
- LANES=2, IN_W=4, IN_H=1, CH=1.
  - Expect 2 beats: {0x0101,0x0100} with col=0, then {0x0103,0x0102} with col=2 and out_last=1.
- Assert rst_n low mid-stream after beat 3.
  - Outputs clear asynchronously: out_valid=0, in_ready=1.
  - The next tensor restarts at beat 0 with coordinates (0,0,0).
- Drive a different in_vec with in_valid=1 during beats 0–6.
  - Streamed data is unaffected.
  - The new vector is accepted only at the last-beat handshake.

Source files
------------

// File: rtl/tensor_pkg.sv
// rtl/tensor_pkg.sv - shared types and index helpers for tensor stream blocks
package tensor_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } ser_state_e;

  localparam int ELEM_IDX_W = 32;

  function automatic int idx_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  // Flat channel-major position of element (c, h, w).
  function automatic int elem_index(input int c, input int h, input int w,
                                    input int in_h, input int in_w);
    return c * in_h * in_w + h * in_w + w;
  endfunction

endpackage

// File: rtl/tensor_index_counter.sv
// rtl/tensor_index_counter.sv - three-level wrapping (ch, row, col) counter
module tensor_index_counter
  import tensor_pkg::*;
#(
  parameter int CH    = 2,
  parameter int IN_H  = 1,
  parameter int IN_W  = 1,
  parameter int LANES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  output logic [idx_width(CH)-1:0]   ch,
  output logic [idx_width(IN_H)-1:0] row,
  output logic [idx_width(IN_W)-1:0] col,
  output logic                       last
);

  localparam int CH_W = idx_width(CH);
  localparam int H_W  = idx_width(IN_H);
  localparam int W_W  = idx_width(IN_W);

  localparam logic [CH_W-1:0] CH_MAX   = CH_W'(CH - 1);
  localparam logic [CH_W-1:0] CH_ONE   = CH_W'(1);
  localparam logic [H_W-1:0]  ROW_MAX  = H_W'(IN_H - 1);
  localparam logic [H_W-1:0]  ROW_ONE  = H_W'(1);
  localparam logic [W_W-1:0]  COL_MAX  = W_W'(IN_W - LANES);
  localparam logic [W_W-1:0]  COL_STEP = W_W'(LANES);

  logic [CH_W-1:0] ch_q, ch_d;
  logic [H_W-1:0]  row_q, row_d;
  logic [W_W-1:0]  col_q, col_d;
  logic            col_wrap, row_wrap, ch_wrap;

  always_comb begin
    ch_d     = ch_q;
    row_d    = row_q;
    col_d    = col_q;
    col_wrap = (col_q == COL_MAX);
    row_wrap = (row_q == ROW_MAX);
    ch_wrap  = (ch_q == CH_MAX);
    // clr wins so a new tensor always starts at (0,0,0) even on the final advance
    if (clr) begin
      ch_d  = '0;
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (!col_wrap) begin
        col_d = col_q + COL_STEP;
      end else begin
        col_d = '0;
        if (!row_wrap) begin
          row_d = row_q + ROW_ONE;
        end else begin
          row_d = '0;
          ch_d  = ch_wrap ? '0 : ch_q + CH_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ch_q  <= ch_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign ch   = ch_q;
  assign row  = row_q;
  assign col  = col_q;
  assign last = col_wrap && row_wrap && ch_wrap;

endmodule

// File: rtl/tensor_serializer2d.sv
// rtl/tensor_serializer2d.sv - streams a flat channel-major tensor as LANES-wide beats
module tensor_serializer2d
  import tensor_pkg::*;
#(
  parameter int CH        = 2,
  parameter int IN_H      = 1,
  parameter int IN_W      = 1,
  parameter int WIDTH     = 16,
  parameter int LANES     = 1,
  parameter     precision = "Q8.8"
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CH*IN_H*IN_W*WIDTH-1:0]   in_vec,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [LANES*WIDTH-1:0]          out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [idx_width(CH)-1:0]        out_ch,
  output logic [idx_width(IN_H)-1:0]      out_row,
  output logic [idx_width(IN_W)-1:0]      out_col
);

  localparam int TENSOR_BITS = CH * IN_H * IN_W * WIDTH;

  generate
    if ((IN_W % LANES) != 0 || precision == "") begin : g_bad_cfg
      $error("tensor_serializer2d: LANES must divide IN_W");
    end
  endgenerate

  ser_state_e             state_q, state_d;
  logic [TENSOR_BITS-1:0] buf_q, buf_d;
  logic [TENSOR_BITS-1:0] shifted;
  logic                   in_fire, out_fire, cnt_last;
  int                     base;

  tensor_index_counter #(
    .CH   (CH),
    .IN_H (IN_H),
    .IN_W (IN_W),
    .LANES(LANES)
  ) u_idx (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (out_fire),
    .clr  (in_fire),
    .ch   (out_ch),
    .row  (out_row),
    .col  (out_col),
    .last (cnt_last)
  );

  always_comb begin
    out_valid = (state_q == S_STREAM);
    out_last  = out_valid && cnt_last;
    // Accepting during the final handshake gives zero-bubble back-to-back tensors.
    in_ready  = !out_valid || (out_ready && cnt_last);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    state_d   = state_q;
    buf_d     = buf_q;
    if (in_fire) begin
      state_d = S_STREAM;
      buf_d   = in_vec;
    end else if (out_fire && cnt_last) begin
      state_d = S_IDLE;
    end
    base     = elem_index(int'(out_ch), int'(out_row), int'(out_col), IN_H, IN_W);
    shifted  = buf_q >> (base * WIDTH);
    out_data = out_valid ? shifted[LANES*WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_tensor_serializer2d.sv
// tb/tb_tensor_serializer2d.sv - self-checking bench for tensor_serializer2d
module tb_tensor_serializer2d;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // A: CH=2 IN_H=2 IN_W=2 LANES=1
  logic [127:0] a_in_vec;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [15:0]  a_out_data;
  logic [0:0]   a_out_ch, a_out_row, a_out_col;
  // B: CH=1 IN_H=1 IN_W=4 LANES=2
  logic [63:0]  b_in_vec;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [31:0]  b_out_data;
  logic [0:0]   b_out_ch, b_out_row;
  logic [1:0]   b_out_col;
  // C: all dimensions 1
  logic [15:0]  c_in_vec;
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic [15:0]  c_out_data;
  logic [0:0]   c_out_ch, c_out_row, c_out_col;

  tensor_serializer2d #(.CH(2), .IN_H(2), .IN_W(2), .WIDTH(16), .LANES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_vec(a_in_vec), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last),
    .out_ch(a_out_ch), .out_row(a_out_row), .out_col(a_out_col));

  tensor_serializer2d #(.CH(1), .IN_H(1), .IN_W(4), .WIDTH(16), .LANES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_vec(b_in_vec), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
    .out_ch(b_out_ch), .out_row(b_out_row), .out_col(b_out_col));

  tensor_serializer2d #(.CH(1), .IN_H(1), .IN_W(1), .WIDTH(16), .LANES(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_vec(c_in_vec), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_last(c_out_last),
    .out_ch(c_out_ch), .out_row(c_out_row), .out_col(c_out_col));

  // Observed bundles: {valid, last, in_ready, ch, row, col, data}
  logic [21:0] obs_a, obs_c;
  logic [38:0] obs_b;
  assign obs_a = {a_out_valid, a_out_last, a_in_ready, a_out_ch, a_out_row, a_out_col, a_out_data};
  assign obs_b = {b_out_valid, b_out_last, b_in_ready, b_out_ch, b_out_row, b_out_col, b_out_data};
  assign obs_c = {c_out_valid, c_out_last, c_in_ready, c_out_ch, c_out_row, c_out_col, c_out_data};

  localparam logic [21:0] IDLE_A = {3'b001, 3'b000, 16'h0000};
  localparam logic [38:0] IDLE_B = {3'b001, 4'b0000, 32'h0000_0000};
  localparam logic [21:0] IDLE_C = {3'b001, 3'b000, 16'h0000};

  // Reference model: element e of a 2x2x2 tensor, coordinates from channel-major order.
  function automatic logic [21:0] exp_a(input logic [127:0] v, input int e, input logic rdy);
    int c, r, w;
    c = e / 4;
    r = (e / 2) % 2;
    w = e % 2;
    return {1'b1, (e == 7), rdy, c[0], r[0], w[0], v[e*16 +: 16]};
  endfunction

  function automatic logic [38:0] exp_b(input logic [63:0] v, input int beat, input logic rdy);
    int e, w;
    e = beat * 2;
    w = e % 4;
    return {1'b1, (beat == 1), rdy, 1'b0, 1'b0, w[1:0], v[(e+1)*16 +: 16], v[e*16 +: 16]};
  endfunction

  function automatic logic [127:0] fixed_vec_a(input logic [15:0] base);
    logic [127:0] v;
    for (int e = 0; e < 8; e++) v[e*16 +: 16] = base + 16'(e);
    return v;
  endfunction

  function automatic logic [127:0] rand_vec_a();
    logic [127:0] v;
    for (int e = 0; e < 8; e++) v[e*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic a_drive(input logic vld, input logic [127:0] vec, input logic rdy);
    @(negedge clk);
    a_in_valid  = vld;
    a_in_vec    = vec;
    a_out_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++; if (obs_a !== IDLE_A) begin failures++; $display("FAIL reset_a got=%h exp=%h", obs_a, IDLE_A); end
    checks++; if (obs_b !== IDLE_B) begin failures++; $display("FAIL reset_b got=%h exp=%h", obs_b, IDLE_B); end
    checks++; if (obs_c !== IDLE_C) begin failures++; $display("FAIL reset_c got=%h exp=%h", obs_c, IDLE_C); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_drive(1'b0, '0, 1'b1);
    checks++; if (obs_a !== IDLE_A) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs_a, IDLE_A); end
  endtask

  task automatic test_stream_basic();
    logic [127:0] v;
    v = fixed_vec_a(16'h0100);
    a_drive(1'b1, v, 1'b1);
    checks++; if (obs_a !== IDLE_A) begin failures++; $display("FAIL basic_accept got=%h exp=%h", obs_a, IDLE_A); end
    for (int b = 0; b < 8; b++) begin
      a_drive(1'b0, v, 1'b1);
      checks++; if (obs_a !== exp_a(v, b, b == 7)) begin failures++; $display("FAIL basic_beat%0d got=%h exp=%h", b, obs_a, exp_a(v, b, b == 7)); end
    end
    a_drive(1'b0, v, 1'b1);
    checks++; if (obs_a !== IDLE_A) begin failures++; $display("FAIL basic_idle got=%h exp=%h", obs_a, IDLE_A); end
  endtask

  task automatic test_backpressure();
    logic [127:0] v;
    logic         rdy;
    int           b, cyc;
    v = rand_vec_a();
    a_drive(1'b1, v, 1'b1);
    b = 0;
    cyc = 0;
    while (b < 8 && cyc < 64) begin
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      a_drive(1'b0, v, rdy);
      checks++; if (obs_a !== exp_a(v, b, rdy && b == 7)) begin failures++; $display("FAIL bp_cyc%0d got=%h exp=%h", cyc, obs_a, exp_a(v, b, rdy && b == 7)); end
      if (rdy) b++;
      cyc++;
    end
    checks++; if (b != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", b); end
    a_drive(1'b0, v, 1'b0);
    checks++; if (obs_a !== IDLE_A) begin failures++; $display("FAIL bp_idle got=%h exp=%h", obs_a, IDLE_A); end
  endtask

  task automatic test_random_ready();
    logic [127:0] v;
    logic         rdy;
    int           b, cyc;
    for (int t = 0; t < 3; t++) begin
      v = rand_vec_a();
      a_drive(1'b1, v, 1'b1);
      b = 0;
      cyc = 0;
      while (b < 8 && cyc < 100) begin
        rdy = 1'($urandom_range(0, 1));
        a_drive(1'b0, v, rdy);
        checks++; if (obs_a !== exp_a(v, b, rdy && b == 7)) begin failures++; $display("FAIL rnd_t%0d_cyc%0d got=%h exp=%h", t, cyc, obs_a, exp_a(v, b, rdy && b == 7)); end
        if (rdy) b++;
        cyc++;
      end
      checks++; if (b != 8) begin failures++; $display("FAIL rnd_timeout got=%0d exp=8", b); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] v1, v2;
    v1 = fixed_vec_a(16'h0100);
    v2 = fixed_vec_a(16'h0200);
    a_drive(1'b1, v1, 1'b1);
    for (int b = 0; b < 8; b++) begin
      a_drive(1'b1, v2, 1'b1);
      checks++; if (obs_a !== exp_a(v1, b, b == 7)) begin failures++; $display("FAIL b2b_first%0d got=%h exp=%h", b, obs_a, exp_a(v1, b, b == 7)); end
    end
    for (int b = 0; b < 8; b++) begin
      a_drive(1'b0, v2, 1'b1);
      checks++; if (obs_a !== exp_a(v2, b, b == 7)) begin failures++; $display("FAIL b2b_second%0d got=%h exp=%h", b, obs_a, exp_a(v2, b, b == 7)); end
    end
    a_drive(1'b0, v2, 1'b1);
    checks++; if (obs_a !== IDLE_A) begin failures++; $display("FAIL b2b_idle got=%h exp=%h", obs_a, IDLE_A); end
  endtask

  task automatic test_ignore_input();
    logic [127:0] v1, v2;
    v1 = rand_vec_a();
    v2 = rand_vec_a();
    a_drive(1'b1, v1, 1'b1);
    for (int b = 0; b < 7; b++) begin
      a_drive(1'b1, rand_vec_a(), 1'b1);
      checks++; if (obs_a !== exp_a(v1, b, 1'b0)) begin failures++; $display("FAIL ign_beat%0d got=%h exp=%h", b, obs_a, exp_a(v1, b, 1'b0)); end
    end
    a_drive(1'b1, v2, 1'b1);
    checks++; if (obs_a !== exp_a(v1, 7, 1'b1)) begin failures++; $display("FAIL ign_last got=%h exp=%h", obs_a, exp_a(v1, 7, 1'b1)); end
    for (int b = 0; b < 8; b++) begin
      a_drive(1'b0, rand_vec_a(), 1'b1);
      checks++; if (obs_a !== exp_a(v2, b, b == 7)) begin failures++; $display("FAIL ign_next%0d got=%h exp=%h", b, obs_a, exp_a(v2, b, b == 7)); end
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] v;
    v = rand_vec_a();
    a_drive(1'b1, v, 1'b1);
    for (int b = 0; b < 4; b++) begin
      a_drive(1'b0, v, 1'b1);
      checks++; if (obs_a !== exp_a(v, b, 1'b0)) begin failures++; $display("FAIL arst_pre%0d got=%h exp=%h", b, obs_a, exp_a(v, b, 1'b0)); end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs_a !== IDLE_A) begin failures++; $display("FAIL arst_clear got=%h exp=%h", obs_a, IDLE_A); end
    @(negedge clk);
    rst_n = 1'b1;
    v = rand_vec_a();
    a_drive(1'b1, v, 1'b1);
    for (int b = 0; b < 8; b++) begin
      a_drive(1'b0, v, 1'b1);
      checks++; if (obs_a !== exp_a(v, b, b == 7)) begin failures++; $display("FAIL arst_restart%0d got=%h exp=%h", b, obs_a, exp_a(v, b, b == 7)); end
    end
  endtask

  task automatic test_lanes2();
    logic [63:0] v;
    for (int e = 0; e < 4; e++) v[e*16 +: 16] = 16'h0100 + 16'(e);
    @(negedge clk); b_in_valid = 1'b1; b_in_vec = v; b_out_ready = 1'b1; #1;
    checks++; if (obs_b !== IDLE_B) begin failures++; $display("FAIL l2_accept got=%h exp=%h", obs_b, IDLE_B); end
    @(negedge clk); b_in_valid = 1'b0; #1;
    checks++; if (obs_b !== {3'b100, 2'b00, 2'd0, 32'h0101_0100}) begin failures++; $display("FAIL l2_beat0 got=%h exp=%h", obs_b, {3'b100, 2'b00, 2'd0, 32'h0101_0100}); end
    @(negedge clk); #1;
    checks++; if (obs_b !== {3'b111, 2'b00, 2'd2, 32'h0103_0102}) begin failures++; $display("FAIL l2_beat1 got=%h exp=%h", obs_b, {3'b111, 2'b00, 2'd2, 32'h0103_0102}); end
    @(negedge clk); #1;
    checks++; if (obs_b !== IDLE_B) begin failures++; $display("FAIL l2_idle got=%h exp=%h", obs_b, IDLE_B); end
    for (int t = 0; t < 3; t++) begin
      for (int e = 0; e < 4; e++) v[e*16 +: 16] = 16'($urandom);
      @(negedge clk); b_in_valid = 1'b1; b_in_vec = v; #1;
      for (int b = 0; b < 2; b++) begin
        @(negedge clk); b_in_valid = 1'b0; #1;
        checks++; if (obs_b !== exp_b(v, b, b == 1)) begin failures++; $display("FAIL l2_rnd%0d_beat%0d got=%h exp=%h", t, b, obs_b, exp_b(v, b, b == 1)); end
      end
    end
  endtask

  task automatic test_degenerate();
    logic [15:0] prev, nxt;
    prev = 16'($urandom);
    @(negedge clk); c_in_valid = 1'b1; c_in_vec = prev; c_out_ready = 1'b1; #1;
    checks++; if (obs_c !== IDLE_C) begin failures++; $display("FAIL deg_accept got=%h exp=%h", obs_c, IDLE_C); end
    for (int t = 0; t < 4; t++) begin
      nxt = 16'($urandom);
      @(negedge clk); c_in_vec = nxt; #1;
      checks++; if (obs_c !== {3'b111, 3'b000, prev}) begin failures++; $display("FAIL deg_beat%0d got=%h exp=%h", t, obs_c, {3'b111, 3'b000, prev}); end
      prev = nxt;
    end
    @(negedge clk); c_in_valid = 1'b0; c_out_ready = 1'b0; #1;
    checks++; if (obs_c !== {3'b110, 3'b000, prev}) begin failures++; $display("FAIL deg_stall got=%h exp=%h", obs_c, {3'b110, 3'b000, prev}); end
    @(negedge clk); c_out_ready = 1'b1; #1;
    checks++; if (obs_c !== {3'b111, 3'b000, prev}) begin failures++; $display("FAIL deg_release got=%h exp=%h", obs_c, {3'b111, 3'b000, prev}); end
    @(negedge clk); #1;
    checks++; if (obs_c !== IDLE_C) begin failures++; $display("FAIL deg_idle got=%h exp=%h", obs_c, IDLE_C); end
  endtask

  initial begin
    a_in_vec = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_vec = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    c_in_vec = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    test_reset();
    test_stream_basic();
    test_backpressure();
    test_random_ready();
    test_back_to_back();
    test_ignore_input();
    test_async_reset();
    test_lanes2();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
